// File: rtl/cva6_l2_tlb_set_assoc.sv
// cva6_l2_tlb_set_assoc: parametrised set-associative L2 TLB bank with tree-PLRU replacement, ASID/VMID tags and flushes
module cva6_l2_tlb_set_assoc #(
    parameter int NR_ENTRIES = 128,
    parameter int ASSOC      = 4,
    parameter int PAGE_LVL   = 0,
    parameter int VPN_WIDTH  = 27,
    parameter int PPN_WIDTH  = 44,
    parameter int ASID_WIDTH = 16,
    parameter int VMID_WIDTH = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_all_i,
    input  logic                  flush_asid_valid_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic                  lookup_valid_i,
    output logic                  lookup_ready_o,
    input  logic [VPN_WIDTH-1:0]  lookup_vpn_i,
    input  logic [ASID_WIDTH-1:0] lookup_asid_i,
    input  logic [VMID_WIDTH-1:0] lookup_vmid_i,
    output logic                  resp_valid_o,
    output logic                  resp_hit_o,
    output logic [PPN_WIDTH-1:0]  resp_ppn_o,
    output logic [7:0]            resp_perm_o,
    input  logic                  refill_valid_i,
    output logic                  refill_ready_o,
    input  logic [VPN_WIDTH-1:0]  refill_vpn_i,
    input  logic [ASID_WIDTH-1:0] refill_asid_i,
    input  logic [VMID_WIDTH-1:0] refill_vmid_i,
    input  logic [PPN_WIDTH-1:0]  refill_ppn_i,
    input  logic [7:0]            refill_perm_i
);
    localparam int SETS   = NR_ENTRIES / ASSOC;
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(ASSOC);
    localparam int EVPN_W = VPN_WIDTH - 9 * PAGE_LVL;
    localparam int TAG_W  = EVPN_W - IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [ASID_WIDTH-1:0] asid;
        logic [VMID_WIDTH-1:0] vmid;
        logic [PPN_WIDTH-1:0]  ppn;
        logic [7:0]            perm;
    } entry_t;

    entry_t                         mem_q [SETS][ASSOC];
    logic [SETS-1:0][ASSOC-1:0]     valid_q;
    logic [SETS-1:0][ASSOC-2:0]     plru_q;
    logic                           resp_valid_q, resp_hit_q;
    logic [PPN_WIDTH-1:0]           resp_ppn_q;
    logic [7:0]                     resp_perm_q;
    logic [EVPN_W-1:0]              l_evpn, r_evpn;
    logic [IDX_W-1:0]               l_idx, r_idx;
    logic [TAG_W-1:0]               l_tag, r_tag;
    logic [ASSOC-1:0]               l_hit, r_match;
    logic [WAY_W-1:0]               l_way, r_way;
    logic                           l_any, lookup_fire, refill_fire;
    entry_t                         l_ent;

    // Walk the tree from the root following the bits; each bit points at the colder half
    function automatic logic [WAY_W-1:0] plru_victim(input logic [ASSOC-2:0] t);
        int n = 0;
        logic [WAY_W-1:0] w = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w = (w << 1) | WAY_W'(t[n]);
            n = 2 * n + 1 + int'(t[n]);
        end
        return w;
    endfunction

    function automatic logic [ASSOC-2:0] plru_touch(input logic [ASSOC-2:0] t, input logic [WAY_W-1:0] w);
        int n = 0;
        logic b;
        for (int l = 0; l < WAY_W; l++) begin
            b = w[WAY_W-1-l];
            t[n] = ~b;
            n = 2 * n + 1 + int'(b);
        end
        return t;
    endfunction

    assign lookup_ready_o = !flush_all_i && !flush_asid_valid_i && !refill_valid_i;
    assign refill_ready_o = !flush_all_i && !flush_asid_valid_i;
    assign lookup_fire    = lookup_valid_i && lookup_ready_o;
    assign refill_fire    = refill_valid_i && refill_ready_o;
    assign l_evpn         = lookup_vpn_i[VPN_WIDTH-1:9*PAGE_LVL];
    assign r_evpn         = refill_vpn_i[VPN_WIDTH-1:9*PAGE_LVL];
    assign l_idx          = l_evpn[IDX_W-1:0];
    assign r_idx          = r_evpn[IDX_W-1:0];
    assign l_tag          = l_evpn[EVPN_W-1:IDX_W];
    assign r_tag          = r_evpn[EVPN_W-1:IDX_W];
    assign l_any          = |l_hit;
    assign l_ent          = mem_q[l_idx][l_way];

    always_comb begin
        l_hit   = '0;
        r_match = '0;
        l_way   = '0;
        for (int w = 0; w < ASSOC; w++) begin
            l_hit[w]   = valid_q[l_idx][w] && mem_q[l_idx][w].tag == l_tag && mem_q[l_idx][w].vmid == lookup_vmid_i &&
                         (mem_q[l_idx][w].perm[5] || mem_q[l_idx][w].asid == lookup_asid_i);
            r_match[w] = valid_q[r_idx][w] && mem_q[r_idx][w].tag == r_tag && mem_q[r_idx][w].vmid == refill_vmid_i &&
                         mem_q[r_idx][w].asid == refill_asid_i;
        end
        for (int w = ASSOC - 1; w >= 0; w--) l_way = l_hit[w] ? WAY_W'(w) : l_way;
    end

    // Overwrite a matching entry first, then fill holes, then fall back to PLRU
    always_comb begin
        r_way = plru_victim(plru_q[r_idx]);
        for (int w = ASSOC - 1; w >= 0; w--) r_way = !valid_q[r_idx][w] ? WAY_W'(w) : r_way;
        for (int w = ASSOC - 1; w >= 0; w--) r_way = r_match[w] ? WAY_W'(w) : r_way;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            plru_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_ppn_q   <= '0;
            resp_perm_q  <= '0;
        end else begin
            resp_valid_q <= lookup_fire;
            resp_hit_q   <= lookup_fire && l_any;
            resp_ppn_q   <= (lookup_fire && l_any) ? l_ent.ppn : '0;
            resp_perm_q  <= (lookup_fire && l_any) ? l_ent.perm : '0;
            if (flush_all_i) begin
                valid_q <= '0;
                plru_q  <= '0;
            end else if (flush_asid_valid_i) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < ASSOC; w++)
                        if (!mem_q[s][w].perm[5] && mem_q[s][w].asid == flush_asid_i) valid_q[s][w] <= 1'b0;
            end else if (refill_valid_i) begin
                valid_q[r_idx][r_way] <= 1'b1;
                plru_q[r_idx]         <= plru_touch(plru_q[r_idx], r_way);
            end else if (lookup_fire && l_any) begin
                plru_q[l_idx] <= plru_touch(plru_q[l_idx], l_way);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_fire) mem_q[r_idx][r_way] <= '{r_tag, refill_asid_i, refill_vmid_i, refill_ppn_i, refill_perm_i};
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_ppn_o   = resp_ppn_q;
    assign resp_perm_o  = resp_perm_q;
endmodule

// File: tb/tb_cva6_l2_tlb_set_assoc.sv
// tb_cva6_l2_tlb_set_assoc: directed checks of lookup, refill, PLRU, flushes and 2M page mode
module tb_cva6_l2_tlb_set_assoc;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_all_i, flush_asid_valid_i;
    logic [15:0] flush_asid_i;
    logic        lookup_valid_i;
    logic [26:0] lookup_vpn_i;
    logic [15:0] lookup_asid_i;
    logic [13:0] lookup_vmid_i;
    logic        refill_valid_i;
    logic [26:0] refill_vpn_i;
    logic [15:0] refill_asid_i;
    logic [13:0] refill_vmid_i;
    logic [43:0] refill_ppn_i;
    logic [7:0]  refill_perm_i;
    logic        lr1, rr1, rv1, rh1, lr2, rr2, rv2, rh2;
    logic [43:0] rp1, rp2;
    logic [7:0]  pm1, pm2;
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk_i = ~clk_i;

    cva6_l2_tlb_set_assoc u1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_all_i(flush_all_i), .flush_asid_valid_i(flush_asid_valid_i),
        .flush_asid_i(flush_asid_i), .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lr1),
        .lookup_vpn_i(lookup_vpn_i), .lookup_asid_i(lookup_asid_i), .lookup_vmid_i(lookup_vmid_i),
        .resp_valid_o(rv1), .resp_hit_o(rh1), .resp_ppn_o(rp1), .resp_perm_o(pm1),
        .refill_valid_i(refill_valid_i), .refill_ready_o(rr1), .refill_vpn_i(refill_vpn_i),
        .refill_asid_i(refill_asid_i), .refill_vmid_i(refill_vmid_i), .refill_ppn_i(refill_ppn_i),
        .refill_perm_i(refill_perm_i)
    );

    cva6_l2_tlb_set_assoc #(.PAGE_LVL(1)) u2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_all_i(flush_all_i), .flush_asid_valid_i(flush_asid_valid_i),
        .flush_asid_i(flush_asid_i), .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lr2),
        .lookup_vpn_i(lookup_vpn_i), .lookup_asid_i(lookup_asid_i), .lookup_vmid_i(lookup_vmid_i),
        .resp_valid_o(rv2), .resp_hit_o(rh2), .resp_ppn_o(rp2), .resp_perm_o(pm2),
        .refill_valid_i(refill_valid_i), .refill_ready_o(rr2), .refill_vpn_i(refill_vpn_i),
        .refill_asid_i(refill_asid_i), .refill_vmid_i(refill_vmid_i), .refill_ppn_i(refill_ppn_i),
        .refill_perm_i(refill_perm_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input bit sel, input logic [26:0] vpn, input logic [15:0] asid, input logic hit,
                          input logic [43:0] ppn, input logic [7:0] perm, input string tag);
        lookup_valid_i = 1'b1;
        lookup_vpn_i   = vpn;
        lookup_asid_i  = asid;
        lookup_vmid_i  = '0;
        @(posedge clk_i);
        #1;
        lookup_valid_i = 1'b0;
        chk({tag, ".valid"}, sel ? rv2 : rv1, 1);
        chk({tag, ".hit"}, sel ? rh2 : rh1, hit);
        chk({tag, ".ppn"}, sel ? rp2 : rp1, ppn);
        chk({tag, ".perm"}, sel ? pm2 : pm1, perm);
    endtask

    task automatic refill(input logic [26:0] vpn, input logic [15:0] asid, input logic [43:0] ppn, input logic [7:0] perm);
        refill_valid_i = 1'b1;
        refill_vpn_i   = vpn;
        refill_asid_i  = asid;
        refill_vmid_i  = '0;
        refill_ppn_i   = ppn;
        refill_perm_i  = perm;
        @(posedge clk_i);
        #1;
        refill_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        {flush_all_i, flush_asid_valid_i, lookup_valid_i, refill_valid_i} = '0;
        {flush_asid_i, lookup_vpn_i, lookup_asid_i, lookup_vmid_i} = '0;
        {refill_vpn_i, refill_asid_i, refill_vmid_i, refill_ppn_i, refill_perm_i} = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.valid", rv1, 0);
        chk("rst.hit", rh1, 0);
        chk("rst.ppn", rp1, 0);
        chk("rst.perm", pm1, 0);
        chk("rst.lready", lr1, 1);
        chk("rst.rready", rr1, 1);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        lookup(0, 27'h1234, 16'd1, 0, 0, 0, "cold");
        @(posedge clk_i);
        #1;
        chk("cold.pulse", rv1, 0);

        refill(27'h1234, 16'd1, 44'hABCDE, 8'hCF);
        lookup(0, 27'h1234, 16'd1, 1, 44'hABCDE, 8'hCF, "hit_a1");
        lookup(0, 27'h1234, 16'd2, 0, 0, 0, "miss_a2");
        refill(27'h1234, 16'd1, 44'hABCDE, 8'hEF);
        lookup(0, 27'h1234, 16'd2, 1, 44'hABCDE, 8'hEF, "glob_a2");

        for (int i = 0; i < 4; i++) refill(27'(i * 32), 16'd1, 44'(256 + i), 8'hCF);
        lookup(0, 27'h040, 16'd1, 1, 44'h102, 8'hCF, "plru_h2");
        lookup(0, 27'h000, 16'd1, 1, 44'h100, 8'hCF, "plru_h0");
        lookup(0, 27'h020, 16'd1, 1, 44'h101, 8'hCF, "plru_h1");
        refill(27'h080, 16'd1, 44'h180, 8'hCF);
        lookup(0, 27'h060, 16'd1, 0, 0, 0, "plru_evict3");
        lookup(0, 27'h000, 16'd1, 1, 44'h100, 8'hCF, "plru_keep0");
        lookup(0, 27'h080, 16'd1, 1, 44'h180, 8'hCF, "plru_new");

        refill(27'h300, 16'd5, 44'h11, 8'hCF);
        refill(27'h301, 16'd5, 44'h22, 8'hCF);
        refill(27'h302, 16'd5, 44'h33, 8'hEF);
        flush_asid_valid_i = 1'b1;
        flush_asid_i = 16'd5;
        #1;
        chk("fasid.lready", lr1, 0);
        chk("fasid.rready", rr1, 0);
        @(posedge clk_i);
        #1;
        flush_asid_valid_i = 1'b0;
        lookup(0, 27'h300, 16'd5, 0, 0, 0, "fasid_ng0");
        lookup(0, 27'h301, 16'd5, 0, 0, 0, "fasid_ng1");
        lookup(0, 27'h302, 16'd5, 1, 44'h33, 8'hEF, "fasid_glob");
        lookup(0, 27'h000, 16'd1, 1, 44'h100, 8'hCF, "fasid_other");
        flush_all_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_all_i = 1'b0;
        lookup(0, 27'h302, 16'd5, 0, 0, 0, "fall_glob");
        lookup(0, 27'h1234, 16'd2, 0, 0, 0, "fall_1234");

        refill_valid_i = 1'b1;
        refill_vpn_i = 27'h555;
        refill_asid_i = 16'd3;
        refill_ppn_i = 44'h55;
        refill_perm_i = 8'hCF;
        lookup_valid_i = 1'b1;
        lookup_vpn_i = 27'h555;
        lookup_asid_i = 16'd3;
        #1;
        chk("both.lready", lr1, 0);
        chk("both.rready", rr1, 1);
        @(posedge clk_i);
        #1;
        refill_valid_i = 1'b0;
        lookup_valid_i = 1'b0;
        chk("both.noresp", rv1, 0);
        lookup(0, 27'h555, 16'd3, 1, 44'h55, 8'hCF, "both_retry");
        refill(27'h555, 16'd3, 44'h66, 8'hCF);
        lookup(0, 27'h555, 16'd3, 1, 44'h66, 8'hCF, "overwrite");

        lookup_valid_i = 1'b1;
        lookup_vpn_i = 27'h555;
        lookup_asid_i = 16'd3;
        @(posedge clk_i);
        #1;
        lookup_vpn_i = 27'h556;
        chk("b2b0.valid", rv1, 1);
        chk("b2b0.hit", rh1, 1);
        @(posedge clk_i);
        #1;
        lookup_valid_i = 1'b0;
        chk("b2b1.valid", rv1, 1);
        chk("b2b1.hit", rh1, 0);

        flush_all_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_all_i = 1'b0;
        refill(27'h40000, 16'd1, 44'h77, 8'hCF);
        lookup(1, 27'h401FF, 16'd1, 1, 44'h77, 8'hCF, "lvl1_in");
        lookup(1, 27'h40200, 16'd1, 0, 0, 0, "lvl1_out");
        lookup(0, 27'h401FF, 16'd1, 0, 0, 0, "lvl0_exact");

        lookup(0, 27'h40000, 16'd1, 1, 44'h77, 8'hCF, "pre_arst");
        lookup_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst.valid", rv1, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        lookup(0, 27'h40000, 16'd1, 0, 0, 0, "post_arst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
